// File: rtl/fb_write_sequencer.sv
// Frame-buffer write-bus scheduler. On each frame pulse it grants the shared write bus to
// every enabled draw source in ascending index order, bounds each grant with a watchdog,
// then requests a buffer swap and waits for its acknowledge. Frame pulses that arrive
// while a pass is in progress are remembered (single depth) and counted as overruns.
module fb_write_sequencer #(
  parameter int unsigned NUM_SOURCES    = 4,
  parameter int unsigned SEL_W          = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1,
  parameter int unsigned TIMEOUT_CYCLES = 420000,
  parameter int unsigned OVR_W          = 8
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   frame,
  input  logic [NUM_SOURCES-1:0] src_enable,
  input  logic [NUM_SOURCES-1:0] src_done,
  input  logic                   swap_ack,
  input  logic                   clear_flags,
  output logic [SEL_W-1:0]       write_source_sel,
  output logic [NUM_SOURCES-1:0] src_start,
  output logic                   swap_req,
  output logic                   busy,
  output logic [NUM_SOURCES-1:0] timeout_flags,
  output logic [OVR_W-1:0]       overrun_cnt
);

  localparam int unsigned IDX_W = SEL_W + 1;
  localparam int unsigned WD_W  = $clog2(TIMEOUT_CYCLES);

  localparam logic [IDX_W-1:0] END_IDX  = IDX_W'(NUM_SOURCES);
  localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [OVR_W-1:0] OVR_MAX  = {OVR_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_START,
    S_WAIT,
    S_SWAP,
    S_WAIT_ACK
  } state_t;

  state_t                 r_state;
  logic [IDX_W-1:0]       r_idx;
  logic [WD_W-1:0]        r_wdog;
  logic                   r_pending;
  logic [SEL_W-1:0]       r_sel;
  logic [NUM_SOURCES-1:0] r_src_start;
  logic                   r_swap_req;
  logic                   r_busy;
  logic [NUM_SOURCES-1:0] r_flags;
  logic [OVR_W-1:0]       r_ovr;

  logic [NUM_SOURCES-1:0] w_idx_hot;
  logic                   w_en_hit;
  logic                   w_done_hit;
  logic                   w_timeout;
  logic                   w_overrun;
  logic [IDX_W-1:0]       w_idx_inc;
  logic [NUM_SOURCES-1:0] w_flags_base;
  logic [NUM_SOURCES-1:0] w_flags_set;
  logic [OVR_W-1:0]       w_ovr_inc;

  // One-hot view of the scan index; all-zero once the index passes the last source
  assign w_idx_hot  = NUM_SOURCES'(1) << r_idx;
  assign w_en_hit   = |(src_enable & w_idx_hot);
  assign w_done_hit = |(src_done & w_idx_hot);
  assign w_idx_inc  = r_idx + IDX_W'(1);

  // Watchdog expiry only counts when the granted source has not just finished
  assign w_timeout  = (r_state == S_WAIT) && !w_done_hit && (r_wdog == WD_LIMIT);
  assign w_overrun  = frame && (r_state != S_IDLE);

  assign w_flags_base = clear_flags ? {NUM_SOURCES{1'b0}} : r_flags;
  assign w_flags_set  = w_timeout ? w_idx_hot : {NUM_SOURCES{1'b0}};
  assign w_ovr_inc    = (r_ovr == OVR_MAX) ? r_ovr : r_ovr + OVR_W'(1);

  // Sequencer FSM: scan sources, grant, watch, then swap; outputs registered here
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_wdog      <= '0;
      r_pending   <= 1'b0;
      r_sel       <= '0;
      r_src_start <= '0;
      r_swap_req  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_src_start <= '0;
      r_swap_req  <= 1'b0;
      if (w_overrun) begin
        r_pending <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (frame || r_pending) begin
            r_state   <= S_SCAN;
            r_idx     <= '0;
            r_busy    <= 1'b1;
            r_pending <= 1'b0;
          end
        end
        S_SCAN: begin
          if (r_idx >= END_IDX) begin
            r_state    <= S_SWAP;
            r_swap_req <= 1'b1;
          end else if (w_en_hit) begin
            r_state     <= S_START;
            r_src_start <= w_idx_hot;
            r_sel       <= r_idx[SEL_W-1:0];
            r_wdog      <= '0;
          end else begin
            r_idx <= w_idx_inc;
          end
        end
        S_START: begin
          // The start cycle is part of the source's bus time
          r_state <= S_WAIT;
          r_wdog  <= r_wdog + WD_W'(1);
        end
        S_WAIT: begin
          if (w_done_hit || w_timeout) begin
            r_state <= S_SCAN;
            r_idx   <= w_idx_inc;
          end else begin
            r_wdog <= r_wdog + WD_W'(1);
          end
        end
        S_SWAP: begin
          r_state <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (swap_ack) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Sticky timeout flags and saturating overrun count; a new event beats a same-cycle clear
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_flags <= '0;
      r_ovr   <= '0;
    end else begin
      r_flags <= w_flags_base | w_flags_set;
      if (w_overrun) begin
        r_ovr <= clear_flags ? OVR_W'(1) : w_ovr_inc;
      end else if (clear_flags) begin
        r_ovr <= '0;
      end
    end
  end

  assign write_source_sel = r_sel;
  assign src_start        = r_src_start;
  assign swap_req         = r_swap_req;
  assign busy             = r_busy;
  assign timeout_flags    = r_flags;
  assign overrun_cnt      = r_ovr;

endmodule

// File: tb/tb_fb_write_sequencer.sv
// Scoreboard bench for fb_write_sequencer (3 sources, 16-cycle watchdog, 2-bit overrun count).
// Stimulus pushes the expected start/swap events with their cycle numbers; a negedge monitor
// pops and compares every start or swap pulse the DUT produces.
module tb_fb_write_sequencer;

  localparam int unsigned NS = 3;

  typedef struct packed {
    logic        is_swap;
    logic [2:0]  hot;
    logic [1:0]  sel;
    logic [31:0] cyc;
  } ev_t;

  logic          clk;
  logic          resetN;
  logic          frame;
  logic [NS-1:0] src_enable;
  logic [NS-1:0] src_done;
  logic          swap_ack;
  logic          clear_flags;
  logic [1:0]    write_source_sel;
  logic [NS-1:0] src_start;
  logic          swap_req;
  logic          busy;
  logic [NS-1:0] timeout_flags;
  logic [1:0]    overrun_cnt;

  logic [NS-1:0] resp_done;
  logic [NS-1:0] man_done;

  int  cyc;
  int  n_vec;
  int  n_err;
  int  sel1_cnt;
  int  dly [NS];
  int  due [NS];
  int  ack_due;
  ev_t exp_q [$];

  assign src_done = resp_done | man_done;

  fb_write_sequencer #(
    .NUM_SOURCES    (NS),
    .SEL_W          (2),
    .TIMEOUT_CYCLES (16),
    .OVR_W          (2)
  ) dut (
    .clk              (clk),
    .resetN           (resetN),
    .frame            (frame),
    .src_enable       (src_enable),
    .src_done         (src_done),
    .swap_ack         (swap_ack),
    .clear_flags      (clear_flags),
    .write_source_sel (write_source_sel),
    .src_start        (src_start),
    .swap_req         (swap_req),
    .busy             (busy),
    .timeout_flags    (timeout_flags),
    .overrun_cnt      (overrun_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic frame_go(output int t);
    t = cyc;
    frame = 1'b1;
    tick();
    frame = 1'b0;
  endtask

  task automatic exp_start(input int i, input int c);
    ev_t e;
    e.is_swap = 1'b0;
    e.hot     = 3'(1 << i);
    e.sel     = 2'(i);
    e.cyc     = 32'(c);
    exp_q.push_back(e);
  endtask

  task automatic exp_swap(input int c);
    ev_t e;
    e.is_swap = 1'b1;
    e.hot     = 3'b000;
    e.sel     = 2'd0;
    e.cyc     = 32'(c);
    exp_q.push_back(e);
  endtask

  task automatic pulse_clear();
    clear_flags = 1'b1;
    tick();
    clear_flags = 1'b0;
  endtask

  // Source and frame-manager models: done after dly cycles, ack two cycles after a swap request
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    for (int i = 0; i < NS; i++) resp_done[i] = (cyc == due[i]);
    swap_ack = (cyc == ack_due);
  end

  // Monitor: every start/swap pulse must match the head of the expected-event queue
  always @(negedge clk) begin
    ev_t obs;
    ev_t e;
    if (resetN === 1'b1) begin
      if (write_source_sel == 2'd1) sel1_cnt++;
      if (swap_req === 1'b1) ack_due = cyc + 2;
      for (int i = 0; i < NS; i++) begin
        if (src_start[i] === 1'b1 && dly[i] != 0) due[i] = cyc + dly[i];
      end
      if (src_start != 3'b000 || swap_req === 1'b1) begin
        obs.is_swap = swap_req;
        obs.hot     = src_start;
        obs.sel     = swap_req ? 2'd0 : write_source_sel;
        obs.cyc     = 32'(cyc);
        if (exp_q.size() == 0) begin
          chk("unexpected_event", 64'(obs), 64'(0));
        end else begin
          e = exp_q.pop_front();
          chk("event", 64'(obs), 64'(e));
        end
      end
    end
  end

  initial begin
    int t;
    cyc = 0; n_vec = 0; n_err = 0; sel1_cnt = 0; ack_due = -100;
    for (int i = 0; i < NS; i++) begin dly[i] = 10; due[i] = -100; end
    resetN = 1'b0; frame = 1'b0; src_enable = '0; man_done = '0; resp_done = '0;
    swap_ack = 1'b0; clear_flags = 1'b0;
    repeat (3) tick();

    // Reset state
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_sel", 64'(write_source_sel), 64'(0));
    chk("rst_start", 64'(src_start), 64'(0));
    chk("rst_swap", 64'(swap_req), 64'(0));
    chk("rst_flags", 64'(timeout_flags), 64'(0));
    chk("rst_ovr", 64'(overrun_cnt), 64'(0));
    resetN = 1'b1;
    repeat (2) tick();

    // T1: all enabled, done 10 cycles after each start
    src_enable = 3'b111;
    chk("t1_idle_busy", 64'(busy), 64'(0));
    frame_go(t);
    exp_start(0, t + 2); exp_start(1, t + 14); exp_start(2, t + 26); exp_swap(t + 38);
    chk("t1_busy_t1", 64'(busy), 64'(1));
    wait_until(t + 40);
    chk("t1_busy_ack", 64'(busy), 64'(1));
    tick();
    chk("t1_busy_done", 64'(busy), 64'(0));
    repeat (3) tick();

    // T2: source 1 masked
    src_enable = 3'b101;
    sel1_cnt = 0;
    frame_go(t);
    exp_start(0, t + 2); exp_start(2, t + 15); exp_swap(t + 27);
    wait_until(t + 29);
    chk("t2_busy_ack", 64'(busy), 64'(1));
    tick();
    chk("t2_busy_done", 64'(busy), 64'(0));
    chk("t2_sel1_cycles", 64'(sel1_cnt), 64'(0));
    repeat (3) tick();

    // T3: source 1 never completes -> watchdog after 16 bus cycles
    src_enable = 3'b111;
    dly[1] = 0;
    frame_go(t);
    exp_start(0, t + 2); exp_start(1, t + 14); exp_start(2, t + 31); exp_swap(t + 43);
    wait_until(t + 29);
    chk("t3_flags_before", 64'(timeout_flags), 64'(0));
    tick();
    chk("t3_flags_timeout", 64'(timeout_flags), 64'(3'b010));
    wait_until(t + 46);
    chk("t3_busy_done", 64'(busy), 64'(0));

    // T3b: done in the watchdog's last cycle counts as done
    src_enable = 3'b010;
    dly[1] = 15;
    frame_go(t);
    exp_start(1, t + 3); exp_swap(t + 21);
    wait_until(t + 22);
    chk("t3b_flags_sticky", 64'(timeout_flags), 64'(3'b010));
    wait_until(t + 24);
    chk("t3b_busy_done", 64'(busy), 64'(0));
    pulse_clear();
    chk("t3b_flags_clear", 64'(timeout_flags), 64'(0));

    // T3c: clear coinciding with a timeout -> timeout wins
    dly[1] = 0;
    frame_go(t);
    exp_start(1, t + 3); exp_swap(t + 21);
    wait_until(t + 18);
    pulse_clear();
    chk("t3c_flags_clr_vs_to", 64'(timeout_flags), 64'(3'b010));
    wait_until(t + 24);
    pulse_clear();
    chk("t3c_flags_clear", 64'(timeout_flags), 64'(0));
    dly[1] = 10;

    // T4: two extra frames during WAIT -> count 2, one extra pass
    src_enable = 3'b001;
    frame_go(t);
    exp_start(0, t + 2); exp_swap(t + 16); exp_start(0, t + 21); exp_swap(t + 35);
    wait_until(t + 5);
    frame = 1'b1; tick(); frame = 1'b0;
    wait_until(t + 7);
    frame = 1'b1; tick(); frame = 1'b0;
    chk("t4_ovr_two", 64'(overrun_cnt), 64'(2));
    wait_until(t + 19);
    chk("t4_idle_gap", 64'(busy), 64'(0));
    tick();
    chk("t4_pending_pass", 64'(busy), 64'(1));
    wait_until(t + 45);
    chk("t4_no_third_pass", 64'(busy), 64'(0));
    chk("t4_ovr_hold", 64'(overrun_cnt), 64'(2));

    // T4b: saturation, then clear coinciding with an overrun in the ack exit cycle
    pulse_clear();
    chk("t4b_ovr_clear", 64'(overrun_cnt), 64'(0));
    src_enable = 3'b000;
    frame_go(t);
    exp_swap(t + 5); exp_swap(t + 13);
    frame = 1'b1;
    repeat (5) tick();
    frame = 1'b0;
    chk("t4b_ovr_sat", 64'(overrun_cnt), 64'(3));
    wait_until(t + 7);
    frame = 1'b1; clear_flags = 1'b1;
    tick();
    frame = 1'b0; clear_flags = 1'b0;
    chk("t4b_ovr_clr_vs_ovr", 64'(overrun_cnt), 64'(1));
    chk("t4b_idle_gap", 64'(busy), 64'(0));
    tick();
    chk("t4b_pending_pass", 64'(busy), 64'(1));
    wait_until(t + 16);
    chk("t4b_busy_done", 64'(busy), 64'(0));

    // T5: done during START ignored, stray done of another source ignored
    src_enable = 3'b001;
    dly[0] = 3;
    frame_go(t);
    exp_start(0, t + 2); exp_swap(t + 9);
    wait_until(t + 2);
    man_done = 3'b001; tick();
    man_done = 3'b100; tick();
    man_done = 3'b000;
    wait_until(t + 12);
    chk("t5_busy_done", 64'(busy), 64'(0));
    dly[0] = 10;

    // T6: asynchronous reset while waiting on source 1
    src_enable = 3'b111;
    dly[1] = 0;
    frame_go(t);
    exp_start(0, t + 2); exp_start(1, t + 14);
    wait_until(t + 16);
    resetN = 1'b0;
    #1;
    chk("t6_rst_busy", 64'(busy), 64'(0));
    chk("t6_rst_sel", 64'(write_source_sel), 64'(0));
    chk("t6_rst_start", 64'(src_start), 64'(0));
    chk("t6_rst_ovr", 64'(overrun_cnt), 64'(0));
    repeat (2) tick();
    resetN = 1'b1;
    dly[1] = 10;
    repeat (20) tick();
    chk("t6_idle_after_rst", 64'(busy), 64'(0));
    chk("t6_queue_after_rst", 64'(exp_q.size()), 64'(0));
    src_enable = 3'b001;
    frame_go(t);
    exp_start(0, t + 2); exp_swap(t + 16);
    wait_until(t + 19);
    chk("t6_busy_done", 64'(busy), 64'(0));

    // Drain: every expected event must have been seen
    for (int k = 0; k < 50 && exp_q.size() != 0; k++) tick();
    chk("queue_drained", 64'(exp_q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
